// File: rtl/hwag_pkg.sv
// Shared constants and FSM state type for the hwag SPI-to-register-file bridge.
package hwag_pkg;

  localparam int SSRAM_ADDR_W   = 8;
  localparam int SSRAM_DATA_W   = 16;
  localparam int SPI_FRAME_BITS = 32;
  localparam int SPI_HDR_BITS   = 16;

  typedef enum logic [2:0] {
    WAIT_CS,
    IDLE,
    HDR,
    RD_REQ,
    DATA,
    WR
  } spi_br_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with registered rise/fall strobes for one async pin.
// Latency: level after STAGES clk, strobes after STAGES+1 clk; no backpressure.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= (sync << 1) | STAGES'(din);
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
      fall <= ~sync[STAGES-1] & prev;
    end
  end

  assign level = sync[STAGES-1];

endmodule

// File: rtl/hwag_spi_ssram_bridge.sv
// SPI mode-0 slave turning 32-bit frames into single ssram_256 word writes/reads.
// Latency: strobe 1 clk after the 16th/32nd synced SCK rise; no backpressure (host paces SCK).
module hwag_spi_ssram_bridge
  import hwag_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spi_sck,
  input  logic                    spi_cs_n,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  output logic                    ssram_we,
  output logic                    ssram_re,
  output logic [SSRAM_ADDR_W-1:0] ssram_addr,
  output logic [SSRAM_DATA_W-1:0] ssram_wdata,
  output logic                    ssram_data_oe,
  input  logic [SSRAM_DATA_W-1:0] ssram_rdata,
  output logic                    frame_err
);

  logic sck_unused_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_unused_rise, mosi_unused_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .rst(rst), .din(spi_sck),
    .level(sck_unused_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst(rst), .din(spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .rst(rst), .din(spi_mosi),
    .level(mosi_lvl), .rise(mosi_unused_rise), .fall(mosi_unused_fall)
  );

  spi_br_state_t           state, state_nxt;
  logic [5:0]              bit_cnt;
  logic [7:0]              lat_cnt;
  logic [SSRAM_DATA_W-1:0] shift_sr;
  logic [SSRAM_DATA_W-1:0] miso_sr;
  logic                    is_wr;
  logic                    in_frame, hdr_done, wr_go, rd_load, frame_end;

  always_comb begin
    state_nxt = state;
    hdr_done  = 1'b0;
    wr_go     = 1'b0;
    rd_load   = 1'b0;
    in_frame  = (state == HDR) || (state == RD_REQ) || (state == DATA) || (state == WR);
    frame_end = in_frame && cs_rise;
    case (state)
      WAIT_CS: if (cs_lvl) state_nxt = IDLE;
      IDLE:    if (cs_fall) state_nxt = HDR;
      HDR: begin
        if (cs_rise) state_nxt = IDLE;
        else if (sck_rise && bit_cnt == 6'd15) begin
          hdr_done  = 1'b1;
          state_nxt = shift_sr[14] ? DATA : RD_REQ;
        end
      end
      RD_REQ: begin
        if (cs_rise) state_nxt = IDLE;
        else if (lat_cnt == 8'(RD_LAT)) begin
          rd_load   = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (cs_rise) state_nxt = IDLE;
        else if (sck_rise && bit_cnt == 6'd31 && is_wr) begin
          wr_go     = 1'b1;
          state_nxt = WR;
        end
      end
      WR:      if (cs_rise) state_nxt = IDLE;
      default: state_nxt = WAIT_CS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_CS;
      bit_cnt       <= '0;
      lat_cnt       <= '0;
      shift_sr      <= '0;
      miso_sr       <= '0;
      is_wr         <= 1'b0;
      spi_miso      <= 1'b0;
      ssram_we      <= 1'b0;
      ssram_re      <= 1'b0;
      ssram_data_oe <= 1'b0;
      ssram_addr    <= '0;
      ssram_wdata   <= '0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_nxt;
      ssram_we      <= wr_go;
      ssram_data_oe <= wr_go;
      ssram_re      <= hdr_done && !shift_sr[14];
      frame_err     <= frame_end && (bit_cnt != 6'd32);

      if (state == IDLE && cs_fall) bit_cnt <= '0;
      else if (in_frame && sck_rise && bit_cnt < 6'd33) bit_cnt <= bit_cnt + 6'd1;

      if (sck_rise) shift_sr <= {shift_sr[SSRAM_DATA_W-2:0], mosi_lvl};

      if (hdr_done) begin
        ssram_addr <= {shift_sr[6:0], mosi_lvl};
        is_wr      <= shift_sr[14];
      end

      // MOSI for the last bit settles long before its SCK strobe, so tracking it here
      // gives wdata a full cycle of setup ahead of the write strobe.
      if (state == DATA && is_wr && bit_cnt == 6'd31)
        ssram_wdata <= {shift_sr[SSRAM_DATA_W-2:0], mosi_lvl};

      if (state == RD_REQ) lat_cnt <= lat_cnt + 8'd1;
      else lat_cnt <= '0;

      if (rd_load) begin
        miso_sr  <= ssram_rdata;
        spi_miso <= 1'b0;
      end else if (state == DATA && !is_wr) begin
        if (sck_fall) begin
          spi_miso <= miso_sr[SSRAM_DATA_W-1];
          miso_sr  <= miso_sr << 1;
        end
      end else begin
        spi_miso <= 1'b0;
      end
    end
  end

endmodule

// File: doc/hwag_spi_ssram_bridge.md
# hwag_spi_ssram_bridge

SPI slave that converts fixed 32-bit host frames into single-word write and read cycles on the hwag register file (`ssram_256`). It sits directly upstream of that register file, driving its `ssram_we`, `ssram_re` and `ssram_addr` inputs and both directions of its 16-bit data bus. SPI signals are oversampled in the `clk` domain; no second clock exists in the block.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `spi_sck`, `spi_cs_n` and `spi_mosi`.
- `RD_LAT`, default 1: clk cycles from `ssram_re` high until `ssram_rdata` is valid.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: **reset, synchronous, active-high**. Only clock domain is `clk`.
- `spi_sck` in 1: SPI clock, mode 0, asynchronous.
- `spi_cs_n` in 1: chip select, active-low, asynchronous.
- `spi_mosi` in 1: host data, MSB first.
- `spi_miso` out 1: read data, MSB first.
- `ssram_we` out 1: one-cycle write strobe.
- `ssram_re` out 1: one-cycle read strobe.
- `ssram_addr` out 8: word address.
- `ssram_wdata` out 16: write data. Top level drives the `ssram_data` inout from this when `ssram_data_oe` is high.
- `ssram_data_oe` out 1: write-data drive enable.
- `ssram_rdata` in 16: the `ssram_data` bus as seen on reads.
- `frame_err` out 1: one-cycle pulse on a malformed frame.

## Operation
- Frame layout, MSB first:
  - Bits 31..16 are the header: bit 31 selects write (1) or read (0); bits 30..24 are reserved and ignored; bits 23..16 are the address.
  - Bits 15..0 are the data.
- Edge detection: rising and falling SCK edges and CS edges are found from the synchronized signals; the falling-CS edge is `cs_fall`. MOSI is sampled on rising SCK; MISO is updated on falling SCK.
- FSM states: `WAIT_CS`, `IDLE`, `HDR`, `RD_REQ`, `DATA`, `WR`.
  - `WAIT_CS`: entered on reset. Leaves to `IDLE` only once synchronized CS is high.
  - `IDLE`: on `cs_fall`, clear the 6-bit bit counter and go to `HDR`.
  - `HDR`: shift 16 bits. After the 16th bit, latch `ssram_addr` and go to `RD_REQ` for a read or `DATA` for a write.
  - `RD_REQ`: pulse `ssram_re` for 1 cycle. Wait `RD_LAT` cycles, load `ssram_rdata` into the MISO shift register, then go to `DATA`.
  - `DATA`: shift 16 bits. After the 32nd bit of a write, go to `WR`. After the 32nd bit of a read, go to `IDLE` once CS rises.
  - `WR`: `ssram_we` and `ssram_data_oe` are high for exactly one cycle, then the FSM waits for CS high and goes to `IDLE`.
- MISO content:
  - 0 during the header and for the whole of a write frame.
  - During a read, the `ssram_rdata` bits 15..0.
- Bit counter saturates at 33.
- On CS rise:
  - Count < 32: abort with no `ssram_we`, pulse `frame_err`, go to `IDLE`.
  - Count > 32: the single write (or read) has already happened; pulse `frame_err`; extra bits have no effect.
- No address auto-increment. Address 0xFF is a legal address with no wrap behaviour.
- Reset mid-frame: everything returns to reset values in `WAIT_CS`. A frame whose CS was already low at reset is ignored entirely.

## Timing
- Reset values: `ssram_we`, `ssram_re`, `ssram_data_oe`, `spi_miso` and `frame_err` are 0; `ssram_addr` is 0x00; `ssram_wdata` is 0x0000.
- Input latency: `SYNC_STAGES` + 1 clk from a pin edge to its edge strobe.
- Write: `ssram_we` rises 1 clk after the 32nd rising-SCK strobe. `ssram_addr` and `ssram_wdata` are stable from at least 1 cycle before `ssram_we` until at least 1 cycle after it.
- Read: `ssram_re` rises 1 clk after the 16th rising-SCK strobe. Data is latched `RD_LAT` clk later, and must be in place before the next falling-SCK strobe.
- SCK constraint: high and low times must each be ≥ `SYNC_STAGES` + `RD_LAT` + 3 clk. The host guarantees this; the bridge does not check it.
- CS high time between frames: ≥ `SYNC_STAGES` + 2 clk.
- `ssram_we` and `ssram_re` are never both high in the same cycle.

## Structure
- Shared package `hwag_pkg` holds:
  - `SSRAM_ADDR_W` = 8, `SSRAM_DATA_W` = 16, `SPI_FRAME_BITS` = 32.
  - Enum `spi_br_state_t` for the FSM states.
- One sub-module, `spi_sync_edge`: an N-stage synchronizer plus rise/fall strobe, instantiated once each for SCK, CS and MOSI. MOSI uses only the synchronized level.

## Test plan
- **Write frame:** 0x8012BEEF → `ssram_we` one pulse with `ssram_addr` = 0x12, `ssram_wdata` = 0xBEEF, `ssram_data_oe` = 1. MISO all 0 and `frame_err` = 0.
- **Read frame:** 0x00340000 with the model returning 0xA5C3 at address 0x34 → one `ssram_re` pulse with address 0x34; MISO bits 15..0 read 0xA5C3 and `ssram_we` never fires.
- **Short frame:** write frame aborted by CS rise after 20 bits → no `ssram_we`, one `frame_err` pulse, next valid frame is accepted.
- **Long frame:** 40-bit frame whose first 32 bits are 0x80FF0001 → exactly one write of 0x0001 to address 0xFF, then `frame_err` on CS rise.
- **Reset mid-frame:** `rst` asserted after 10 bits with CS still low, remaining bits clocked → no strobes. After a CS high period, a fresh frame 0x80050055 writes 0x0055 to address 0x05.
- **Back-to-back frames:** write 0x11 ← 0x1111 then read 0x11 with minimum CS gap → the read returns 0x1111, with one `ssram_we` and one `ssram_re` in total.
